// File: rtl/hms_clock_pkg.sv
// Shared types and constants for the HH.MM.SS clock: modes, 7-segment glyphs,
// digit enables and small arithmetic helpers.
package hms_clock_pkg;

    localparam int unsigned TIME_W = 6;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSE    = 2'd1,
        SET_HOUR = 2'd2,
        SET_MIN  = 2'd3
    } mode_t;

    // Active-low segments, bit 7 = decimal point (off), bits 6:0 = g..a
    localparam logic [7:0] NUMBER_0  = 8'hC0;
    localparam logic [7:0] NUMBER_1  = 8'hF9;
    localparam logic [7:0] NUMBER_2  = 8'hA4;
    localparam logic [7:0] NUMBER_3  = 8'hB0;
    localparam logic [7:0] NUMBER_4  = 8'h99;
    localparam logic [7:0] NUMBER_5  = 8'h92;
    localparam logic [7:0] NUMBER_6  = 8'h82;
    localparam logic [7:0] NUMBER_7  = 8'hF8;
    localparam logic [7:0] NUMBER_8  = 8'h80;
    localparam logic [7:0] NUMBER_9  = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] DP_MASK   = 8'h7F;

    localparam logic [5:0] DIGIT_BLOCK_1 = 6'b111110;
    localparam logic [5:0] DIGIT_BLOCK_2 = 6'b111101;
    localparam logic [5:0] DIGIT_BLOCK_3 = 6'b111011;
    localparam logic [5:0] DIGIT_BLOCK_4 = 6'b110111;
    localparam logic [5:0] DIGIT_BLOCK_5 = 6'b101111;
    localparam logic [5:0] DIGIT_BLOCK_6 = 6'b011111;

    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_of = NUMBER_0;
            4'd1:    seg_of = NUMBER_1;
            4'd2:    seg_of = NUMBER_2;
            4'd3:    seg_of = NUMBER_3;
            4'd4:    seg_of = NUMBER_4;
            4'd5:    seg_of = NUMBER_5;
            4'd6:    seg_of = NUMBER_6;
            4'd7:    seg_of = NUMBER_7;
            4'd8:    seg_of = NUMBER_8;
            4'd9:    seg_of = NUMBER_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v == max) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [3:0] units_of(input logic [TIME_W-1:0] v);
        return 4'(v % TIME_W'(10));
    endfunction

    function automatic logic [3:0] tens_of(input logic [TIME_W-1:0] v);
        return 4'(v / TIME_W'(10));
    endfunction

endpackage

// File: rtl/hms_clock_key_debounce.sv
// Active-low key conditioner: 2-flop synchroniser, stability counter and a
// single-cycle press pulse when a new low level is accepted.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hms_clock.sv
// 24-hour HH.MM.SS clock with set mode and 6-digit multiplexed 7-segment scan.
// Optional HMS_CLOCK_BLINK_EN blinks the digits being edited in set modes.
module hms_clock
    import hms_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned SCAN_DIV        = 50_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_pause,
    input  logic       key_inc,
    output logic [7:0] number,
    output logic [5:0] digit_block,
    output logic [1:0] mode
);
    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic mode_p, pause_p, inc_p;
    logic mode_win_c, pause_win_c, inc_win_c, tick_c;

    mode_t               mode_q, mode_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TIME_W-1:0]   sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [5:0]          digit_q, digit_d, next_digit_c;
    logic [7:0]          number_q, number_d, pattern_c;
    logic [3:0]          glyph_c;
    logic                dp_c, edit_hr_c, edit_min_c, blink_on_c;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk(clk), .rst(rst), .key_n(key_mode), .press(mode_p));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
        .clk(clk), .rst(rst), .key_n(key_pause), .press(pause_p));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk(clk), .rst(rst), .key_n(key_inc), .press(inc_p));

    // Priority: mode over pause over inc
    assign mode_win_c  = mode_p;
    assign pause_win_c = pause_p & ~mode_p;
    assign inc_win_c   = inc_p & ~mode_p & ~pause_p;
    assign tick_c      = (mode_q == RUN) && (presc_q == PRESC_W'(CLK_HZ - 1));

    // Mode FSM, prescaler and time counters; ticks use the registered mode
    always_comb begin
        mode_d  = mode_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        if (mode_q == RUN) presc_d = tick_c ? '0 : presc_q + 1'b1;
        if (tick_c) begin
            sec_d = wrap_inc(sec_q, TIME_W'(59));
            if (sec_q == TIME_W'(59)) begin
                min_d = wrap_inc(min_q, TIME_W'(59));
                if (min_q == TIME_W'(59)) hr_d = wrap_inc(hr_q, TIME_W'(23));
            end
        end
        case (mode_q)
            RUN, PAUSE: begin
                if (mode_win_c) begin
                    mode_d  = SET_HOUR;
                    presc_d = '0;
                end else if (pause_win_c) begin
                    mode_d = (mode_q == RUN) ? PAUSE : RUN;
                end
            end
            SET_HOUR: begin
                if (mode_win_c)     mode_d = SET_MIN;
                else if (inc_win_c) hr_d   = wrap_inc(hr_q, TIME_W'(23));
            end
            SET_MIN: begin
                if (mode_win_c) begin
                    mode_d  = RUN;
                    sec_d   = '0;
                    presc_d = '0;
                end else if (inc_win_c) begin
                    min_d = wrap_inc(min_q, TIME_W'(59));
                end
            end
        endcase
    end

`ifdef HMS_CLOCK_BLINK_EN
    logic [PRESC_W-1:0] blink_q, blink_d;

    assign blink_d    = (blink_q == PRESC_W'(CLK_HZ - 1)) ? '0 : blink_q + 1'b1;
    assign blink_on_c = (blink_q < PRESC_W'(CLK_HZ / 2));

    always_ff @(posedge clk) begin
        if (rst) blink_q <= '0;
        else     blink_q <= blink_d;
    end
`else
    assign blink_on_c = 1'b0;
`endif

    assign next_digit_c = {digit_q[4:0], digit_q[5]};

    // Glyph for the digit that becomes active at the next scan wrap
    always_comb begin
        glyph_c    = '0;
        dp_c       = 1'b0;
        edit_hr_c  = 1'b0;
        edit_min_c = 1'b0;
        case (next_digit_c)
            DIGIT_BLOCK_1: glyph_c = units_of(sec_q);
            DIGIT_BLOCK_2: glyph_c = tens_of(sec_q);
            DIGIT_BLOCK_3: begin glyph_c = units_of(min_q); dp_c = 1'b1; edit_min_c = 1'b1; end
            DIGIT_BLOCK_4: begin glyph_c = tens_of(min_q);  edit_min_c = 1'b1; end
            DIGIT_BLOCK_5: begin glyph_c = units_of(hr_q);  dp_c = 1'b1; edit_hr_c = 1'b1; end
            DIGIT_BLOCK_6: begin glyph_c = tens_of(hr_q);   edit_hr_c = 1'b1; end
            default: ;
        endcase
        if (blink_on_c && ((edit_hr_c && mode_q == SET_HOUR) || (edit_min_c && mode_q == SET_MIN)))
            pattern_c = SEG_BLANK;
        else
            pattern_c = seg_of(glyph_c) & (dp_c ? DP_MASK : SEG_BLANK);
    end

    // Scan: digit enable and segment pattern update together at wrap
    always_comb begin
        scan_d   = scan_q + 1'b1;
        digit_d  = digit_q;
        number_d = number_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d   = '0;
            digit_d  = next_digit_c;
            number_d = pattern_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= RUN;
            presc_q  <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hr_q     <= '0;
            scan_q   <= '0;
            digit_q  <= DIGIT_BLOCK_1;
            number_q <= SEG_BLANK;
        end else begin
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
            scan_q   <= scan_d;
            digit_q  <= digit_d;
            number_q <= number_d;
        end
    end

    assign number      = number_q;
    assign digit_block = digit_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_hms_clock.sv
// Directed bench for hms_clock with CLK_HZ=100, SCAN_DIV=4, DEBOUNCE_CYCLES=3.
module tb_hms_clock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b1;
    logic       key_pause = 1'b1;
    logic       key_inc = 1'b1;
    logic [7:0] number;
    logic [5:0] digit_block;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    hms_clock #(.CLK_HZ(100), .SCAN_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_pause(key_pause),
        .key_inc(key_inc), .number(number), .digit_block(digit_block), .mode(mode));

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       key_mode  = v;
            1:       key_pause = v;
            default: key_inc   = v;
        endcase
    endtask

    // k: 0 = mode, 1 = pause, 2 = inc; pulse lands 5 edges after the drive
    task automatic press(input int k);
        set_key(k, 1'b0);
        cyc(10);
        set_key(k, 1'b1);
        cyc(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_hr"},  32'(dut.hr_q),  32'(h));
        chk({tag, "_min"}, 32'(dut.min_q), 32'(m));
        chk({tag, "_sec"}, 32'(dut.sec_q), 32'(s));
    endtask

    initial begin
        int blank_cnt, bad_cnt, hr_seen;

        // Reset state
        cyc(3);
        chk("rst_number", 32'(number), 32'h0FF);
        chk("rst_digit", 32'(digit_block), 32'h3E);
        chk("rst_mode", 32'(mode), 32'd0);
        rst = 1'b0;

        // Free run for 61 seconds
        cyc(6100);
        chk_time("run61", 0, 1, 1);
        chk("run61_digit", 32'(digit_block), 32'h3D);
        chk("run61_number", 32'(number), 32'hC0);
        cyc(20);
        chk("scan_secu_digit", 32'(digit_block), 32'h3E);
        chk("scan_secu_number", 32'(number), 32'hF9);
        cyc(3);
        chk("scan_hold_digit", 32'(digit_block), 32'h3E);
        cyc(1);
        chk("scan_sect_digit", 32'(digit_block), 32'h3D);
        chk("scan_sect_number", 32'(number), 32'hC0);
        cyc(4);
        chk("scan_minu_digit", 32'(digit_block), 32'h3B);
        chk("scan_minu_number", 32'(number), 32'h79);

        // Preload 23:59:59 through set mode, then roll over
        do_reset();
        press(0);
        chk("set_hour_mode", 32'(mode), 32'd2);
        repeat (23) press(2);
        chk("set_hour_23", 32'(dut.hr_q), 32'd23);
        press(0);
        chk("set_min_mode", 32'(mode), 32'd3);
        repeat (59) press(2);
        chk_time("preload", 23, 59, 0);
        press(0);
        chk("exit_run_mode", 32'(mode), 32'd0);
        cyc(5888);
        chk_time("pre_roll", 23, 59, 59);
        cyc(100);
        chk_time("rollover", 0, 0, 0);

        // Pause holds time and prescaler, resume continues exactly
        do_reset();
        cyc(500);
        chk_time("at5", 0, 0, 5);
        press(1);
        chk("pause_mode", 32'(mode), 32'd1);
        cyc(500);
        chk("pause_held_mode", 32'(mode), 32'd1);
        chk_time("paused", 0, 0, 5);
        press(1);
        chk("resume_mode", 32'(mode), 32'd0);
        chk_time("resume", 0, 0, 5);
        cyc(81);
        chk("resume_pre_tick", 32'(dut.sec_q), 32'd5);
        cyc(1);
        chk("resume_tick", 32'(dut.sec_q), 32'd6);

        // Bounced inc key gives one increment; minute wrap does not carry
        do_reset();
        press(0);
        repeat (5) press(2);
        press(0);
        chk("bounce_mode", 32'(mode), 32'd3);
        key_inc = 1'b0; cyc(1);
        key_inc = 1'b1; cyc(1);
        key_inc = 1'b0; cyc(20);
        key_inc = 1'b1; cyc(8);
        chk_time("bounce", 5, 1, 0);
        repeat (58) press(2);
        chk("min_59", 32'(dut.min_q), 32'd59);
        press(2);
        chk_time("min_wrap", 5, 0, 0);

        // Mode beats pause; mid-operation reset
        do_reset();
        key_mode = 1'b0;
        key_pause = 1'b0;
        cyc(10);
        key_mode = 1'b1;
        key_pause = 1'b1;
        cyc(8);
        chk("simul_mode", 32'(mode), 32'd2);
        press(2);
        press(0);
        press(2);
        chk("pre_rst_mode", 32'(mode), 32'd3);
        chk_time("pre_rst", 1, 1, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_number", 32'(number), 32'h0FF);
        chk("mid_rst_digit", 32'(digit_block), 32'h3E);
        chk_time("mid_rst", 0, 0, 0);

        // Hour digits in SET_HOUR: blink only when the feature is built
        do_reset();
        press(0);
        press(2);
        press(2);
        blank_cnt = 0;
        bad_cnt   = 0;
        hr_seen   = 0;
        for (int i = 0; i < 240; i++) begin
            cyc(1);
            case (digit_block)
                6'b101111: begin
                    hr_seen++;
                    if (number == 8'hFF) blank_cnt++;
                    else if (number != 8'h24) bad_cnt++;
                end
                6'b011111: begin
                    hr_seen++;
                    if (number == 8'hFF) blank_cnt++;
                    else if (number != 8'hC0) bad_cnt++;
                end
                6'b111011: if (number != 8'h40) bad_cnt++;
                6'b110111: if (number != 8'hC0) bad_cnt++;
                default: ;
            endcase
        end
        chk("set_hr_seen", 32'(hr_seen != 0), 32'd1);
        chk("set_hr_bad", 32'(bad_cnt), 32'd0);
`ifdef HMS_CLOCK_BLINK_EN
        chk("blink_blank", 32'(blank_cnt != 0), 32'd1);
        chk("blink_shown", 32'(blank_cnt < hr_seen), 32'd1);
`else
        chk("steady_blank", 32'(blank_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hms_clock.md
# hms_clock

Parametrised 24-hour HH.MM.SS clock with a 6-digit multiplexed 7-segment display driver and debounced front-panel keys. It succeeds the fixed-constant timer: clock rate, scan rate and debounce time are parameters, and a set mode lets the user adjust hours and minutes from keys. It sits between the board clock/keys and the segment/digit pins.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; one second = CLK_HZ cycles
- SCAN_DIV, 50_000, clock cycles each digit stays lit before the scan advances
- DEBOUNCE_CYCLES, 500_000, cycles a key must be stable before it is accepted
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- key_mode  in  1  raw mode key, active-low, asynchronous to clk
- key_pause  in  1  raw pause key, active-low, asynchronous
- key_inc  in  1  raw increment key, active-low, asynchronous
- number  out  8  segment pattern, active-low; bit 7 = decimal point, bits 6:0 = g..a
- digit_block  out  6  digit enable, one-hot active-low; bit 0 = seconds units
- mode  out  2  current mode, for status LEDs

## Operation
- Modes: RUN=0, PAUSE=1, SET_HOUR=2, SET_MIN=3. Reset → RUN, 00:00:00.
- Prescaler counts 0..CLK_HZ-1 only in RUN. When it reaches CLK_HZ-1 it wraps to 0 and a tick fires.
- Tick carry chain: seconds 59→0 carries to minutes; minutes 59→0 carries to hours; hours 23→0 with no carry. Fields are 6-bit binary.
- Mode transitions, acting only on one-cycle debounced press pulses:
  - RUN/PAUSE + mode → SET_HOUR; the prescaler clears.
  - SET_HOUR + mode → SET_MIN.
  - SET_MIN + mode → RUN; seconds and the prescaler clear.
  - RUN + pause → PAUSE; PAUSE + pause → RUN. The prescaler holds its value in PAUSE.
  - SET_HOUR + inc: hours +1, 23→0. SET_MIN + inc: minutes +1, 59→0, with no carry into hours.
  - inc is ignored in RUN/PAUSE. pause is ignored in SET modes.
- Simultaneous pulses: mode beats pause, and pause beats inc. Only the winning pulse is acted on that cycle.
- A tick and a key pulse in the same cycle: the tick applies using the registered (current) mode. The new mode takes effect the next cycle.
- Display: the scan counter counts 0..SCAN_DIV-1. At wrap, digit_block rotates left by one (bit 5 wraps to bit 0) and number loads the pattern for the newly selected digit.
  - Digit order, bit0..bit5: sec units, sec tens, min units, min tens, hr units, hr tens.
  - The decimal point (bit 7 = 0) is lit on min units and hr units. Tens are shown without leading-zero blanking.
- Reset mid-operation: every register returns to its reset value on the next clk edge, regardless of mode or pending pulses.

## Timing
- Reset values: number = 8'hFF (blank), digit_block = 6'b111110, mode = RUN, all counters 0.
- Key path: 2-flop synchroniser, then a stable counter. The press pulse is asserted exactly 1 cycle, 2+DEBOUNCE_CYCLES cycles after the raw low level settles. A release produces no pulse.
- A held key produces exactly one pulse.
- A key/tick effect is visible on the time registers 1 cycle after the pulse or tick. It reaches number at the next scan wrap that selects that digit.
- number and digit_block are registered and change in the same cycle. There is no blank gap between digits.

## Configuration
- HMS_CLOCK_BLINK_EN defined: in SET_HOUR the two hour digits output 8'hFF while a blink phase counter is in its first half-second. In SET_MIN the minute digits blink the same way. The blink phase is a free-running counter of period CLK_HZ cycles that also runs in SET modes.
- Undefined: no blink counter is built, and set-mode digits display steadily.

## Structure
- hms_clock_pkg holds:
  - mode_t enum (RUN/PAUSE/SET_HOUR/SET_MIN)
  - 7-seg constants NUMBER_0..NUMBER_9 and SEG_BLANK
  - digit one-hot constants DIGIT_BLOCK_1..6
  - a seg_of(digit) function
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, key_n, press) is instantiated three times.
- The top level contains the prescaler, time counters, mode FSM and scan mux.

## Test plan
Bench parameters: CLK_HZ=100, SCAN_DIV=4, DEBOUNCE_CYCLES=3.
- Run from reset for 100·61 cycles → time 00:01:01; digit_block cycles 111110→111101→… every 4 cycles; number shows NUMBER_1 on sec units.
- Preload 23:59:59 via set mode (hours to 23, minutes to 59, exit), advance 59 s, then one tick → 00:00:00.
- key_pause low 10 cycles at time 00:00:05, wait 500 cycles, press again → time still 00:00:05 at the second press, then resumes; exactly one toggle per press.
- Bounce key_inc (low 1 cycle, high 1, low 2) then hold low in SET_MIN → exactly one minutes increment; minutes 59 + inc → 00 with hours unchanged.
- key_mode and key_pause pulses in the same cycle from RUN → mode=SET_HOUR, pause not applied; assert rst for 1 cycle in SET_MIN → RUN, 00:00:00, number=8'hFF, digit_block=6'b111110.
- With HMS_CLOCK_BLINK_EN defined, in SET_HOUR → hour digits read 8'hFF for the first 50 cycles of each 100-cycle phase; without the macro they are never 8'hFF.
